// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: fetch FSM encoding, NOP word and reset PC.
package instruction_fetch_pkg;

  localparam logic [31:0] NopInstr       = 32'h0000_0000;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] PcStep         = 32'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2,
    StDrain = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: reset clears, flush inserts a bubble, load captures a new
// instruction, otherwise holds (stall).
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o
);

  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  // A bubble keeps pc_plus4 so decode still sees the last known fetch PC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q    <= NopInstr;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
    end else if (flush_i) begin
      instr_q    <= NopInstr;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC and request FSM over a req/ack instruction memory, feeding the
// IF/ID register. The request address never moves while a request is outstanding.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        if_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_buf_q, instr_buf_d;

  logic [31:0]  pc_inc;
  logic [31:0]  target;
  logic         ifid_load;
  logic         ifid_flush;
  logic [31:0]  ifid_instr;

  assign pc_inc = pc_q + PcStep;
  assign target = word_align(branch_target);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    instr_buf_d = instr_buf_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_instr  = imem_rdata;

    unique case (state_q)
      StIdle: begin
        state_d    = StFetch;
        req_addr_d = pc_q;
        if (branch_taken) begin
          pc_d       = target;
          req_addr_d = target;
          ifid_flush = 1'b1;
        end
      end

      StFetch: begin
        if (branch_taken) begin
          pc_d       = target;
          ifid_flush = 1'b1;
          // An unacked request must keep its address; DRAIN retires it first.
          if (imem_ack) begin
            req_addr_d = target;
          end else begin
            state_d = StDrain;
          end
        end else if (imem_ack) begin
          if (stall) begin
            instr_buf_d = imem_rdata;
            state_d     = StHold;
          end else begin
            ifid_load  = 1'b1;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
      end

      StHold: begin
        if (branch_taken) begin
          instr_buf_d = NopInstr;
          pc_d        = target;
          req_addr_d  = target;
          ifid_flush  = 1'b1;
          state_d     = StFetch;
        end else if (!stall) begin
          ifid_load  = 1'b1;
          ifid_instr = instr_buf_q;
          pc_d       = pc_inc;
          req_addr_d = pc_inc;
          state_d    = StFetch;
        end
      end

      StDrain: begin
        if (branch_taken) begin
          pc_d = target;
        end
        if (branch_taken || !stall) begin
          ifid_flush = 1'b1;
        end
        // Stale data is dropped; the next request uses the latest redirect.
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = StFetch;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      instr_buf_q <= NopInstr;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  assign imem_req  = !rst && ((state_q == StFetch) || (state_q == StDrain));
  assign imem_addr = req_addr_q;

  if_id_reg u_if_id_reg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ifid_load),
    .flush_i    (ifid_flush),
    .instr_i    (ifid_instr),
    .pc_plus4_i (pc_inc),
    .instr_o    (instruction),
    .pc_plus4_o (pc_plus4),
    .valid_o    (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random
// stall/branch/ack traffic scored against an in-order instruction-stream model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc_plus4;
  logic        if_valid;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned consumed = 0;
  logic [31:0] exp_pc = 32'h0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc_plus4      (pc_plus4),
    .if_valid      (if_valid)
  );

  // Memory contents: a fixed scramble of the address, never equal to the NOP word.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA000_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
  endtask

  // One clock, entered and left just after a falling edge. Decode consumes the IF/ID
  // word at every edge without stall/branch/reset; consumed words must walk the
  // program in order from the last redirect.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic a);
    logic        pre_req, pre_valid, outstanding;
    logic [31:0] pre_addr, pre_instr, pre_p4;
    rst = r;
    stall = s;
    branch_taken = b;
    branch_target = t;
    #1;
    pre_req   = imem_req;
    pre_addr  = imem_addr;
    pre_valid = if_valid;
    pre_instr = instruction;
    pre_p4    = pc_plus4;
    imem_ack   = a && pre_req;
    imem_rdata = imem_ack ? mem(pre_addr) : $urandom;
    if (r) begin
      chk1("req_in_reset", imem_req, 1'b0);
    end else if (b) begin
      exp_pc = {t[31:2], 2'b00};
    end else if (!s && pre_valid) begin
      chk("consume_instr", pre_instr, mem(exp_pc));
      chk("consume_pc_plus4", pre_p4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    outstanding = !r && pre_req && !imem_ack;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      exp_pc = 32'h0;
      chk1("reset_valid", if_valid, 1'b0);
      chk("reset_instr", instruction, 32'h0);
      chk("reset_pc_plus4", pc_plus4, 32'h0);
    end else if (b) begin
      chk1("flush_valid", if_valid, 1'b0);
      chk("flush_instr", instruction, 32'h0);
    end else if (s) begin
      chk1("hold_valid", if_valid, pre_valid);
      chk("hold_instr", instruction, pre_instr);
      chk("hold_pc_plus4", pc_plus4, pre_p4);
    end
    if (outstanding) begin
      chk1("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, pre_addr);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("idle_req", imem_req, 1'b0);
    chk1("idle_valid", if_valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk1("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
  endtask

  initial begin
    logic        r, s, b, a;
    logic [31:0] t;
    @(negedge clk);

    // Reset and zero-wait streaming
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("stream_instr", instruction, mem(32'(4 * i)));
      chk("stream_pc_plus4", pc_plus4, 32'(4 * i + 4));
      chk1("stream_valid", if_valid, 1'b1);
    end

    // Stall on the ack of 0x8 while IF/ID holds 0x4
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_stall_addr", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk1("hold_no_req", imem_req, 1'b0);
      chk("stall_keeps_0x4", instruction, mem(32'h4));
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("after_stall_instr", instruction, mem(32'h8));
    chk("after_stall_pc_plus4", pc_plus4, 32'hC);
    chk("no_refetch_addr", imem_addr, 32'hC);

    // Branch in the same cycle as the ack of 0x10
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("at_0x10", imem_addr, 32'h10);
    cycle(1'b0, 1'b0, 1'b1, 32'h103, 1'b1);
    chk("branch_ack_addr", imem_addr, 32'h100);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("target_instr", instruction, mem(32'h100));

    // Branch to 0x200 while 0x20 waits on memory
    cycle(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    chk("drain_addr", imem_addr, 32'h20);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drain_done_addr", imem_addr, 32'h200);
    chk1("drain_bubble", if_valid, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("after_drain_instr", instruction, mem(32'h200));

    // Wrap past the top of memory, then reset during HOLD
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk1("in_hold_req", imem_req, 1'b0);
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("restart_instr", instruction, mem(32'h0));

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(99) == 0);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 6);
      a = ($urandom_range(99) < 60);
      t = ($urandom_range(1) == 0) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(15)));
      cycle(r, s, b, t, a);
    end
    chk1("forward_progress", consumed > 600, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the MIPS pipeline: holds the program counter, issues requests to instruction memory over a req/ack handshake, and loads the IF/ID pipeline register that feeds instruction decode.
- Accepts stall from the hazard unit and branch redirect from the branch-resolution logic.
- Inserts NOP bubbles when no instruction is available.
- Never changes the memory address while a request is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode stage cannot accept; hold IF/ID and PC
- branch_taken  in  1  redirect fetch to branch_target and flush IF/ID
- branch_target  in  32  redirect address; bits [1:0] forced to 0
- imem_req  out  1  request to instruction memory
- imem_addr  out  32  word-aligned fetch address, stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  memory completes the current request this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- instruction  out  32  IF/ID instruction word to decode
- pc_plus4  out  32  IF/ID copy of fetch PC+4 for branch target calculation
- if_valid  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Registers: pc, req_addr, buf (32-bit instruction buffer), state, and the IF/ID fields (instruction, pc_plus4, if_valid).
- Reset: state=IDLE, pc=RESET_PC, req_addr=RESET_PC, instruction=32'h0, pc_plus4=32'h0, if_valid=0. imem_req=0 while rst=1.
- imem_req=1 in FETCH and DRAIN, 0 in IDLE and HOLD. imem_addr=req_addr.
- IDLE: go to FETCH the next cycle; req_addr=pc.
- FETCH, branch_taken=1:
  - pc and req_addr load target.
  - IF/ID is flushed (instruction=0, if_valid=0).
  - If imem_ack=1, rdata is discarded and state stays FETCH; otherwise go to DRAIN.
- FETCH, imem_ack=1, stall=0:
  - IF/ID loads {imem_rdata, pc+4, 1}.
  - pc and req_addr load pc+4.
  - State stays FETCH.
- FETCH, imem_ack=1, stall=1:
  - buf loads imem_rdata; IF/ID holds.
  - State goes to HOLD; pc is not yet advanced.
- FETCH, imem_ack=0: if stall=0, IF/ID loads a bubble {0, pc_plus4 unchanged, 0}; if stall=1, IF/ID holds.
- HOLD, branch_taken=1: buf is discarded, pc and req_addr load target, IF/ID is flushed, go to FETCH.
- HOLD, stall=0: IF/ID loads {buf, pc+4, 1}, pc and req_addr load pc+4, go to FETCH.
- HOLD, stall=1: everything holds.
- DRAIN:
  - req_addr holds the stale address until imem_ack.
  - On ack, rdata is discarded, req_addr loads pc, and state goes to FETCH.
  - A branch_taken during DRAIN updates pc only; state stays DRAIN.
  - IF/ID shows bubbles (if_valid=0) unless stall=1.
- Priority: rst > branch_taken > stall > normal fetch.
- Arithmetic: pc+4 is unsigned 32-bit and wraps 32'hFFFF_FFFC to 32'h0000_0000.

## Timing
- With zero-wait memory (ack in the same cycle as req), instruction for address A appears in IF/ID one cycle after the ack edge. Throughput is one instruction per cycle.
- First request is asserted in the second cycle after rst deasserts (IDLE lasts one cycle).
- Branch penalty:
  - If branch_taken arrives while the FETCH request is unacked, one extra cycle is spent in DRAIN per pending memory wait cycle.
  - The target request is issued the cycle after the drain ack.
- stall assertion has effect at the same edge it is sampled high. No instruction is lost or duplicated across any stall pattern.
- All outputs except imem_req and imem_addr are registered. imem_req and imem_addr depend only on state, req_addr, and rst.

## Structure
- Shared package holds:
  - the NOP constant (32'h0000_0000);
  - the state encoding (IDLE, FETCH, HOLD, DRAIN);
  - the default RESET_PC.
- One sub-module: if_id_reg, the IF/ID pipeline register with hold (stall) and flush (bubble) controls and {instruction, pc_plus4, if_valid} fields. The PC/FSM logic stays in instruction_fetch.

## Test plan
- Reset:
  - Hold rst 3 cycles, then release.
  - Required: imem_req=0 during reset and the first post-reset cycle; if_valid=0.
  - Required: first request imem_addr=32'h0000_0000, i.e. RESET_PC.
- Zero-wait streaming:
  - Ack every cycle with rdata = address.
  - Required: IF/ID shows 0x0, 0x4, 0x8 on consecutive cycles with pc_plus4 = 0x4, 0x8, 0xC.
- Stall on ack:
  - Assert stall for 3 cycles on the cycle address 0x8 is acked.
  - Required: IF/ID holds 0x4 throughout; imem_req=0 in HOLD.
  - Required: 0x8 appears once after stall drops and is not refetched.
- Branch in same cycle as ack:
  - At address 0x10, assert ack and branch_taken with target 0x103.
  - Required: if_valid=0 next cycle; next imem_addr=0x100; rdata from 0x10 never reaches IF/ID.
- Branch during wait:
  - Memory has 2 wait cycles; branch to 0x200 while 0x20 is pending.
  - Required: imem_addr stays 0x20 until ack, then becomes 0x200; the 0x20 data is discarded.
- Wrap and reset mid-operation:
  - Branch to 0xFFFF_FFFC; then assert rst during HOLD.
  - Required: next fetch address after 0xFFFF_FFFC is 0x0.
  - Required: the rst cycle clears if_valid and buf; fetch restarts at RESET_PC.
